mips_mc_control: RTL and testbench

- Multi-cycle MIPS main controller; sits directly upstream of the ALU.
- Decodes opcode/funct of the fetched instruction and sequences the datapath through fetch/decode/execute/memory/writeback.
- Drives the 4-bit ALUoperation code the ALU consumes, and uses the ALU Zero flag for beq.
- Supports add, sub, and, or, slt, nor (R-type), addi, lw, sw, beq, j, with a memory ready handshake and a wait timeout.

---
 rtl/mips_pkg.sv | 26 ++
 rtl/alu_decoder.sv | 32 +++
 rtl/mips_mc_control.sv | 163 ++++++++++++++++
 tb/tb_mips_mc_control.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared opcodes, funct codes, ALU op codes and controller state types
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_NOR = 6'b100111;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1000;
  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    RTYPE, RTWB, ADDIEX, ADDIWB, BRANCH, JUMP
  } state_e;
  typedef enum logic [1:0] {CLS_NONE, CLS_ADD, CLS_SUB, CLS_FUNCT} alu_cls_e;
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps the controller's ALU request class and funct to an ALU op code
module alu_decoder
  import mips_pkg::*;
(
  input  alu_cls_e    cls,
  input  logic [5:0]  funct,
  output logic [3:0]  alu_op,
  output logic        funct_valid
);
  // fixed classes pick add/sub directly; the funct class decodes R-type functs
  always_comb begin
    alu_op = ALU_AND;
    funct_valid = 1'b0;
    case (cls)
      CLS_ADD: alu_op = ALU_ADD;
      CLS_SUB: alu_op = ALU_SUB;
      CLS_FUNCT: begin
        funct_valid = 1'b1;
        case (funct)
          F_ADD:   alu_op = ALU_ADD;
          F_SUB:   alu_op = ALU_SUB;
          F_AND:   alu_op = ALU_AND;
          F_OR:    alu_op = ALU_OR;
          F_SLT:   alu_op = ALU_SLT;
          F_NOR:   alu_op = ALU_NOR;
          default: funct_valid = 1'b0;
        endcase
      end
      default: alu_op = ALU_AND;
    endcase
  end
endmodule

// File: rtl/mips_mc_control.sv
// mips_mc_control: multi-cycle MIPS main controller with memory wait timeout
module mips_mc_control
  import mips_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic [3:0] ALUoperation,
  output logic       pc_en,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic       illegal,
  output logic       mem_err
);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CMAX = CW'((TIMEOUT > 0) ? TIMEOUT : 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  alu_cls_e cls;
  logic funct_valid, pc_write, pc_write_cond, mem_state, timeout_hit;
  alu_decoder u_alu_dec (
    .cls         (cls),
    .funct       (funct),
    .alu_op      (ALUoperation),
    .funct_valid (funct_valid)
  );
  assign mem_state   = state_q inside {FETCH, MEMRD, MEMWR};
  assign timeout_hit = (TIMEOUT != 0) && mem_state && !mem_ready && (cnt_q == CMAX);
  assign pc_en       = pc_write | (pc_write_cond & Zero);
  // state and wait counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  // next state and Moore output decode; a timeout overrides to FETCH
  always_comb begin
    state_d = state_q;
    cls = CLS_NONE;
    pc_write = 1'b0;
    pc_write_cond = 1'b0;
    IorD = 1'b0;
    MemRead = 1'b0;
    MemWrite = 1'b0;
    IRWrite = 1'b0;
    RegWrite = 1'b0;
    MemtoReg = 1'b0;
    RegDst = 1'b0;
    ALUSrcA = 1'b0;
    ALUSrcB = 2'b00;
    PCSource = 2'b00;
    illegal = 1'b0;
    mem_err = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        MemRead = 1'b1;
        IRWrite = mem_ready;
        pc_write = mem_ready;
        ALUSrcB = 2'b01;
        cls = CLS_ADD;
        state_d = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        cls = CLS_ADD;
        case (opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = RTYPE;
          OP_ADDI:      state_d = ADDIEX;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          default: begin
            illegal = 1'b1;
            state_d = FETCH;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        cls = CLS_ADD;
        state_d = (opcode == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD = 1'b1;
        state_d = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        state_d = FETCH;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD = 1'b1;
        state_d = mem_ready ? FETCH : MEMWR;
      end
      RTYPE: begin
        ALUSrcA = 1'b1;
        cls = CLS_FUNCT;
        illegal = !funct_valid;
        state_d = funct_valid ? RTWB : FETCH;
      end
      RTWB: begin
        RegDst = 1'b1;
        RegWrite = 1'b1;
        state_d = FETCH;
      end
      ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        cls = CLS_ADD;
        state_d = ADDIWB;
      end
      ADDIWB: begin
        RegWrite = 1'b1;
        state_d = FETCH;
      end
      BRANCH: begin
        ALUSrcA = 1'b1;
        cls = CLS_SUB;
        pc_write_cond = 1'b1;
        PCSource = 2'b01;
        state_d = FETCH;
      end
      JUMP: begin
        pc_write = 1'b1;
        PCSource = 2'b10;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
    if (timeout_hit) begin
      mem_err = 1'b1;
      state_d = FETCH;
    end
  end
  // wait counter: clears on any state change or abort, saturates while stalled
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q || timeout_hit) cnt_d = '0;
    else if (mem_state && !mem_ready && cnt_q != CMAX) cnt_d = cnt_q + 1'b1;
  end
endmodule

// File: tb/tb_mips_mc_control.sv
// tb_mips_mc_control: randomized cycle-by-cycle check against an instruction-level model
module tb_mips_mc_control;
  localparam int TO = 4;
  typedef struct packed {
    logic [3:0] aluop;
    logic pc_en, iord, mrd, mwr, irw, rw, m2r, rdst, srca;
    logic [1:0] srcb, pcs;
    logic ill, merr;
  } out_t;
  typedef struct {
    out_t e;
    logic rdy, z;
    logic [5:0] op, fn;
  } cyc_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic Zero = 1'b0, mem_ready = 1'b0;
  logic [3:0] ALUoperation;
  logic pc_en, IorD, MemRead, MemWrite, IRWrite, RegWrite, MemtoReg, RegDst, ALUSrcA;
  logic [1:0] ALUSrcB, PCSource;
  logic illegal, mem_err;
  out_t obs;
  cyc_t plan[$];
  logic [5:0] cur_op, cur_fn;
  int total = 0, passed = 0;

  mips_mc_control #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .Zero(Zero),
    .mem_ready(mem_ready), .ALUoperation(ALUoperation), .pc_en(pc_en), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .PCSource(PCSource), .illegal(illegal), .mem_err(mem_err)
  );

  always #5 clk = ~clk;
  assign obs = {ALUoperation, pc_en, IorD, MemRead, MemWrite, IRWrite, RegWrite,
                MemtoReg, RegDst, ALUSrcA, ALUSrcB, PCSource, illegal, mem_err};

  function automatic void push(out_t e, logic rdy, logic z);
    cyc_t c;
    c.e = e; c.rdy = rdy; c.z = z; c.op = cur_op; c.fn = cur_fn;
    plan.push_back(c);
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [4:0] alu_of(logic [5:0] f);
    case (f)
      6'b100000: return 5'b1_0010;
      6'b100010: return 5'b1_0110;
      6'b100100: return 5'b1_0000;
      6'b100101: return 5'b1_0001;
      6'b101010: return 5'b1_0111;
      6'b100111: return 5'b1_1000;
      default:   return 5'b0_0000;
    endcase
  endfunction

  // memory phase: s idle cycles then ready; more than TO idle cycles means abort
  function automatic bit plan_mem(int kind, int s);
    out_t e;
    logic rdy;
    int last = (s <= TO) ? s : TO;
    for (int i = 0; i <= last; i++) begin
      e = '0;
      rdy = (s <= TO) && (i == s);
      if (kind == 0) begin
        e.mrd = 1; e.srcb = 2'b01; e.aluop = 4'b0010; e.irw = rdy; e.pc_en = rdy;
      end else if (kind == 1) begin
        e.mrd = 1; e.iord = 1;
      end else begin
        e.mwr = 1; e.iord = 1;
      end
      e.merr = (s > TO) && (i == TO);
      push(e, rdy, rnd());
    end
    return s <= TO;
  endfunction

  function automatic void plan_instr(logic [5:0] op, logic [5:0] fn, logic z, int sf, int sm);
    out_t e;
    logic [4:0] a;
    bit legal;
    cur_op = op; cur_fn = fn;
    if (!plan_mem(0, sf)) return;
    legal = op inside {6'h00, 6'h23, 6'h2b, 6'h08, 6'h04, 6'h02};
    e = '0; e.srcb = 2'b11; e.aluop = 4'b0010; e.ill = !legal;
    push(e, rnd(), rnd());
    if (!legal) return;
    e = '0;
    if (op == 6'h23 || op == 6'h2b) begin
      e.srca = 1; e.srcb = 2'b10; e.aluop = 4'b0010;
      push(e, rnd(), rnd());
      if (plan_mem(op == 6'h2b ? 2 : 1, sm) && op == 6'h23) begin
        e = '0; e.rw = 1; e.m2r = 1;
        push(e, rnd(), rnd());
      end
    end else if (op == 6'h00) begin
      a = alu_of(fn);
      e.srca = 1; e.aluop = a[3:0]; e.ill = !a[4];
      push(e, rnd(), rnd());
      if (a[4]) begin
        e = '0; e.rdst = 1; e.rw = 1;
        push(e, rnd(), rnd());
      end
    end else if (op == 6'h08) begin
      e.srca = 1; e.srcb = 2'b10; e.aluop = 4'b0010;
      push(e, rnd(), rnd());
      e = '0; e.rw = 1;
      push(e, rnd(), rnd());
    end else if (op == 6'h04) begin
      e.srca = 1; e.aluop = 4'b0110; e.pcs = 2'b01; e.pc_en = z;
      push(e, rnd(), z);
    end else begin
      e.pc_en = 1; e.pcs = 2'b10;
      push(e, rnd(), rnd());
    end
  endfunction

  task automatic run_plan(input string name, input int lim);
    int n = (lim < plan.size()) ? lim : plan.size();
    for (int i = 0; i < n; i++) begin
      opcode = plan[i].op; funct = plan[i].fn; mem_ready = plan[i].rdy; Zero = plan[i].z;
      @(negedge clk);
      total++;
      if (obs !== plan[i].e)
        $display("FAIL %s cycle %0d: got %h want %h", name, i, obs, plan[i].e);
      else passed++;
      @(posedge clk); #1;
    end
    plan.delete();
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) begin
      opcode = 6'($urandom); mem_ready = 1; Zero = 1;
      @(negedge clk);
      total++;
      if (obs !== '0) $display("FAIL reset_hold: got %h want 0", obs);
      else passed++;
    end
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    total++;
    if (obs !== '0) $display("FAIL reset_idle: got %h want 0", obs);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_rtype_add();
    plan_instr(6'h00, 6'b100000, 0, 0, 0);
    run_plan("rtype_add", 999);
  endtask

  task automatic test_lw_stall();
    plan_instr(6'h23, 6'h00, 0, 0, 3);
    run_plan("lw_stall", 999);
  endtask

  task automatic test_beq();
    plan_instr(6'h04, 6'h00, 1, 0, 0);
    run_plan("beq_taken", 999);
    plan_instr(6'h04, 6'h00, 0, 0, 0);
    run_plan("beq_not_taken", 999);
  endtask

  task automatic test_illegal();
    plan_instr(6'b111111, 6'h20, 0, 0, 0);
    run_plan("illegal_opcode", 999);
    plan_instr(6'h00, 6'b000000, 0, 0, 0);
    run_plan("illegal_funct", 999);
  endtask

  task automatic test_timeout();
    plan_instr(6'h2b, 6'h00, 0, 0, 99);
    run_plan("sw_timeout", 999);
    plan_instr(6'h2b, 6'h00, 0, 0, TO - 1);
    run_plan("sw_ready_cycle4", 999);
    plan_instr(6'h2b, 6'h00, 0, 0, TO);
    run_plan("sw_ready_at_limit", 999);
    plan_instr(6'h23, 6'h00, 0, 99, 0);
    run_plan("fetch_timeout", 999);
    plan_instr(6'h08, 6'h00, 0, TO, 0);
    run_plan("addi_fetch_at_limit", 999);
  endtask

  task automatic test_reset_mid();
    plan_instr(6'h2b, 6'h00, 0, 0, 99);
    run_plan("sw_before_reset", 3);
    mem_ready = 0;
    @(negedge clk);
    total++;
    if (MemWrite !== 1'b1) $display("FAIL memwr_active: got %b want 1", MemWrite);
    else passed++;
    rst_n = 0;
    #1;
    total++;
    if (obs !== '0) $display("FAIL async_reset: got %h want 0", obs);
    else passed++;
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    total++;
    if (obs !== '0) $display("FAIL reset_release_idle: got %h want 0", obs);
    else passed++;
    @(posedge clk); #1;
    plan_instr(6'h00, 6'b100010, 0, 0, 0);
    run_plan("restart_after_reset", 999);
  endtask

  task automatic test_random();
    logic [5:0] ops [7] = '{6'h00, 6'h23, 6'h2b, 6'h08, 6'h04, 6'h02, 6'h3f};
    logic [5:0] fns [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h27};
    logic [5:0] op, fn;
    int sf, sm;
    for (int k = 0; k < 60; k++) begin
      op = ops[$urandom_range(0, 6)];
      if (op == 6'h3f) op = 6'($urandom);
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 5)];
      sf = ($urandom_range(0, 7) == 0) ? $urandom_range(2, TO + 2) : $urandom_range(0, 1);
      sm = ($urandom_range(0, 4) == 0) ? $urandom_range(2, TO + 2) : $urandom_range(0, 1);
      plan_instr(op, fn, rnd(), sf, sm);
      run_plan("random", 999);
    end
  endtask

  initial begin
    test_reset();
    test_rtype_add();
    test_lw_stall();
    test_beq();
    test_illegal();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
